// File: rtl/unified_cache_2way.sv
// Two-way set-associative write-back, write-allocate unified cache, one word per line.
// A single FSM serves hits, victim write-back, line fetch and a full dirty-line flush walk.
module unified_cache_2way #(
    parameter int WORDS  = 1024,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clka,
    input  logic              rsta_n,
    input  logic              req,
    input  logic              wea,
    input  logic [ADDR_W-1:0] addra,
    input  logic [DATA_W-1:0] dina,
    input  logic              flush_all,
    output logic [DATA_W-1:0] douta,
    output logic              ready,
    output logic              hit,
    output logic              flush_done,
    output logic              fetch,
    input  logic              fetch_ack,
    output logic              flush,
    input  logic              flush_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din
);
    localparam int SETS  = WORDS / 2;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, FLUSH, FETCH, WALK} state_t;

    state_t            state_q;
    logic [TAG_W-1:0]  tag_q   [2][SETS];
    logic [DATA_W-1:0] data_q  [2][SETS];
    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   dirty_q [2];
    logic [SETS-1:0]   lru_q;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              we_q;
    logic              way_q;
    logic              walk_q;
    logic [IDX_W:0]    walk_ptr_q;

    logic [DATA_W-1:0] douta_q, mem_dout_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              hit_q, flush_done_q, fetch_q, flush_q;

    // Lookup of the presented address against both ways of its set.
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic             hit0, hit1, lookup_hit, hit_way, victim, victim_dirty, accept;

    assign idx          = addra[IDX_W-1:0];
    assign tag          = addra[ADDR_W-1:IDX_W];
    assign hit0         = valid_q[0][idx] && (tag_q[0][idx] == tag);
    assign hit1         = valid_q[1][idx] && (tag_q[1][idx] == tag);
    assign lookup_hit   = hit0 || hit1;
    assign hit_way      = hit1;
    assign victim       = !valid_q[0][idx] ? 1'b0 : (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);
    assign victim_dirty = valid_q[victim][idx] && dirty_q[victim][idx];
    assign accept       = (state_q == IDLE) && req && !flush_all;

    // Walk pointer enumerates lines as {set, way}, so way 0 precedes way 1 within a set.
    logic [IDX_W-1:0] walk_idx;
    logic             walk_way, walk_dirty, walk_last;

    assign walk_idx   = walk_ptr_q[IDX_W:1];
    assign walk_way   = walk_ptr_q[0];
    assign walk_dirty = valid_q[walk_way][walk_idx] && dirty_q[walk_way][walk_idx];
    assign walk_last  = &walk_ptr_q;

    // Single line write port shared by write hit, write allocate and fetch fill.
    logic              arr_we, arr_way, arr_dirty;
    logic [IDX_W-1:0]  arr_idx;
    logic [TAG_W-1:0]  arr_tag;
    logic [DATA_W-1:0] arr_data;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case infers a latch.
        arr_we    = 1'b0;
        arr_way   = way_q;
        arr_idx   = addr_q[IDX_W-1:0];
        arr_tag   = addr_q[ADDR_W-1:IDX_W];
        arr_data  = din_q;
        arr_dirty = 1'b1;
        case (state_q)
            IDLE: begin
                if (accept && wea && (lookup_hit || !victim_dirty)) begin
                    arr_we   = 1'b1;
                    arr_way  = lookup_hit ? hit_way : victim;
                    arr_idx  = idx;
                    arr_tag  = tag;
                    arr_data = dina;
                end
            end
            FLUSH: arr_we = flush_ack && !walk_q && we_q;
            FETCH: begin
                if (fetch_ack) begin
                    arr_we    = 1'b1;
                    arr_data  = mem_din;
                    arr_dirty = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // NOTE: tag and data arrays carry no reset; valid bits alone decide whether their contents matter.
    always_ff @(posedge clka) begin
        if (arr_we) begin
            tag_q[arr_way][arr_idx]  <= arr_tag;
            data_q[arr_way][arr_idx] <= arr_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignment so every read sees pre-edge values.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q      <= IDLE;
            valid_q[0]   <= '0;
            valid_q[1]   <= '0;
            dirty_q[0]   <= '0;
            dirty_q[1]   <= '0;
            lru_q        <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            we_q         <= 1'b0;
            way_q        <= 1'b0;
            walk_q       <= 1'b0;
            walk_ptr_q   <= '0;
            douta_q      <= '0;
            hit_q        <= 1'b0;
            flush_done_q <= 1'b0;
            fetch_q      <= 1'b0;
            flush_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_dout_q   <= '0;
        end else begin
            hit_q        <= 1'b0;
            flush_done_q <= 1'b0;
            if (arr_we) begin
                valid_q[arr_way][arr_idx] <= 1'b1;
                dirty_q[arr_way][arr_idx] <= arr_dirty;
                lru_q[arr_idx]            <= ~arr_way;
            end
            case (state_q)
                IDLE: begin
                    if (flush_all) begin
                        state_q    <= WALK;
                        walk_q     <= 1'b1;
                        walk_ptr_q <= '0;
                    end else if (req) begin
                        addr_q <= addra;
                        din_q  <= dina;
                        we_q   <= wea;
                        if (lookup_hit) begin
                            hit_q <= 1'b1;
                            if (!wea) begin
                                douta_q    <= data_q[hit_way][idx];
                                lru_q[idx] <= ~hit_way;
                            end
                        end else begin
                            way_q <= victim;
                            if (victim_dirty) begin
                                state_q    <= FLUSH;
                                flush_q    <= 1'b1;
                                mem_addr_q <= {tag_q[victim][idx], idx};
                                mem_dout_q <= data_q[victim][idx];
                            end else if (!wea) begin
                                state_q    <= FETCH;
                                fetch_q    <= 1'b1;
                                mem_addr_q <= addra;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (flush_ack) begin
                        flush_q <= 1'b0;
                        if (walk_q) begin
                            dirty_q[walk_way][walk_idx] <= 1'b0;
                            if (walk_last) begin
                                flush_done_q <= 1'b1;
                                walk_q       <= 1'b0;
                                state_q      <= IDLE;
                            end else begin
                                walk_ptr_q <= walk_ptr_q + (IDX_W+1)'(1);
                                state_q    <= WALK;
                            end
                        end else if (we_q) begin
                            state_q <= IDLE;
                        end else begin
                            state_q    <= FETCH;
                            fetch_q    <= 1'b1;
                            mem_addr_q <= addr_q;
                        end
                    end
                end
                FETCH: begin
                    if (fetch_ack) begin
                        fetch_q <= 1'b0;
                        douta_q <= mem_din;
                        state_q <= IDLE;
                    end
                end
                WALK: begin
                    if (walk_dirty) begin
                        state_q    <= FLUSH;
                        flush_q    <= 1'b1;
                        mem_addr_q <= {tag_q[walk_way][walk_idx], walk_idx};
                        mem_dout_q <= data_q[walk_way][walk_idx];
                    end else if (walk_last) begin
                        flush_done_q <= 1'b1;
                        walk_q       <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        walk_ptr_q <= walk_ptr_q + (IDX_W+1)'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready      = (state_q == IDLE);
    assign douta      = douta_q;
    assign hit        = hit_q;
    assign flush_done = flush_done_q;
    assign fetch      = fetch_q;
    assign flush      = flush_q;
    assign mem_addr   = mem_addr_q;
    assign mem_dout   = mem_dout_q;

endmodule

// File: tb/tb_unified_cache_2way.sv
// Directed bench for unified_cache_2way: a per-line cache model predicts every visible output,
// checked on each falling edge, with literal expectations for the reference scenarios.
module tb_unified_cache_2way;
    localparam int WORDS  = 1024;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int SETS   = WORDS / 2;

    logic              clka = 1'b0;
    logic              rsta_n, req, wea, flush_all, fetch_ack, flush_ack;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina, mem_din;
    logic [DATA_W-1:0] douta, mem_dout;
    logic [ADDR_W-1:0] mem_addr;
    logic              ready, hit, flush_done, fetch, flush;

    always #5 clka = ~clka;

    unified_cache_2way #(.WORDS(WORDS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clka(clka), .rsta_n(rsta_n), .req(req), .wea(wea), .addra(addra), .dina(dina),
        .flush_all(flush_all), .douta(douta), .ready(ready), .hit(hit), .flush_done(flush_done),
        .fetch(fetch), .fetch_ack(fetch_ack), .flush(flush), .flush_ack(flush_ack),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Model: line l = set*2 + way; mlast holds the most recently used way of a set.
    bit          mv     [WORDS];
    int          mtag   [WORDS];
    logic [31:0] mdata  [WORDS];
    bit          mdirty [WORDS];
    bit          mlast  [SETS];

    logic        exp_ready, exp_hit, exp_fetch, exp_flush, exp_flush_done;
    logic [31:0] exp_douta, exp_mem_dout;
    int          exp_mem_addr;
    bit          cmp_en = 1'b0;
    bit          walk_mode = 1'b0;

    always @(negedge clka) begin
        if (cmp_en) begin
            check("hit", hit, exp_hit);
            check("fetch", fetch, exp_fetch);
            if (!walk_mode) begin
                check("ready", ready, exp_ready);
                check("flush", flush, exp_flush);
                check("flush_done", flush_done, exp_flush_done);
                check("douta", douta, exp_douta);
                if (exp_fetch || exp_flush) check("mem_addr", mem_addr, exp_mem_addr);
                if (exp_flush) check("mem_dout", mem_dout, exp_mem_dout);
            end
        end
    end

    task automatic step();
        @(posedge clka);
        #1;
        exp_hit        = 1'b0;
        exp_flush_done = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) begin
            mv[i]     = 1'b0;
            mdirty[i] = 1'b0;
        end
        for (int i = 0; i < SETS; i++) mlast[i] = 1'b0;
        exp_ready = 1'b1; exp_hit = 1'b0; exp_fetch = 1'b0; exp_flush = 1'b0;
        exp_flush_done = 1'b0; exp_douta = '0; exp_mem_addr = 0; exp_mem_dout = '0;
    endtask

    task automatic install(input int l, input int tg, input logic [31:0] d, input bit dirty);
        mv[l] = 1'b1; mtag[l] = tg; mdata[l] = d; mdirty[l] = dirty;
        mlast[l / 2] = bit'(l % 2);
    endtask

    task automatic do_reset();
        rsta_n = 1'b0;
        model_reset();
        step();
        step();
        rsta_n = 1'b1;
    endtask

    // Busy cycles: garbage on request inputs, optional ack for the wrong transaction.
    task automatic busy_wait(input int n, input bit noise, input bit in_flush);
        for (int i = 0; i < n; i++) begin
            req       = 1'($urandom_range(0, 1));
            wea       = 1'($urandom_range(0, 1));
            flush_all = 1'($urandom_range(0, 1));
            addra     = ADDR_W'($urandom);
            dina      = $urandom;
            if (in_flush) fetch_ack = noise;
            else flush_ack = noise;
            step();
        end
        req = 1'b0; flush_all = 1'b0; fetch_ack = 1'b0; flush_ack = 1'b0;
    endtask

    task automatic access(input bit we, input int addr, input logic [31:0] wdata,
                          input logic [31:0] fill, input int wait_n, input bit noise,
                          output bit saw_hit, output bit saw_flush, output int fl_addr,
                          output logic [31:0] fl_data, output bit saw_fetch, output int fe_addr);
        int s, tg, l, vl;
        bit h;
        s = addr % SETS;
        tg = addr / SETS;
        h = 1'b0; l = 0;
        for (int w = 0; w < 2; w++)
            if (mv[s*2+w] && mtag[s*2+w] == tg) begin h = 1'b1; l = s*2 + w; end
        saw_flush = 1'b0; fl_addr = 0; fl_data = '0; saw_fetch = 1'b0; fe_addr = 0;
        req = 1'b1; wea = we; addra = ADDR_W'(addr); dina = wdata;
        step();
        req = 1'b0;
        saw_hit = hit;
        if (h) begin
            exp_hit = 1'b1;
            mlast[s] = bit'(l % 2);
            if (we) begin mdata[l] = wdata; mdirty[l] = 1'b1; end
            else exp_douta = mdata[l];
            return;
        end
        if (!mv[s*2]) vl = s*2;
        else if (!mv[s*2+1]) vl = s*2 + 1;
        else vl = s*2 + (mlast[s] ? 0 : 1);
        if (mv[vl] && mdirty[vl]) begin
            exp_ready = 1'b0; exp_flush = 1'b1;
            exp_mem_addr = mtag[vl] * SETS + s; exp_mem_dout = mdata[vl];
            saw_flush = flush; fl_addr = int'(mem_addr); fl_data = mem_dout;
            busy_wait(wait_n, noise, 1'b1);
            flush_ack = 1'b1;
            step();
            flush_ack = 1'b0;
            exp_flush = 1'b0;
            mv[vl] = 1'b0;
            if (we) begin install(vl, tg, wdata, 1'b1); exp_ready = 1'b1; return; end
        end else if (we) begin
            install(vl, tg, wdata, 1'b1);
            return;
        end
        exp_ready = 1'b0; exp_fetch = 1'b1; exp_mem_addr = addr;
        saw_fetch = fetch; fe_addr = int'(mem_addr);
        busy_wait(wait_n, noise, 1'b0);
        fetch_ack = 1'b1; mem_din = fill;
        step();
        fetch_ack = 1'b0; mem_din = $urandom;
        exp_fetch = 1'b0; exp_ready = 1'b1; exp_douta = fill;
        install(vl, tg, fill, 1'b0);
    endtask

    task automatic walk(input bit with_req, output int nfl, output int a0, output int a1);
        int q[$];
        int l;
        bit done;
        for (int i = 0; i < WORDS; i++) if (mv[i] && mdirty[i]) q.push_back(i);
        nfl = 0; a0 = -1; a1 = -1; done = 1'b0;
        flush_all = 1'b1; req = with_req; wea = 1'b1; addra = '0; dina = 32'hdead_beef;
        walk_mode = 1'b1;
        step();
        flush_all = 1'b0; req = 1'b0;
        check("walk_busy", ready, 0);
        for (int c = 0; c < 4 * WORDS && !done; c++) begin
            if (flush_done) begin
                done = 1'b1;
            end else if (flush) begin
                if (q.size() == 0) begin
                    check("walk_extra_flush", flush, 0);
                end else begin
                    l = q.pop_front();
                    check("walk_addr", mem_addr, mtag[l] * SETS + l / 2);
                    check("walk_data", mem_dout, mdata[l]);
                    mdirty[l] = 1'b0;
                end
                if (nfl == 0) a0 = int'(mem_addr);
                else if (nfl == 1) a1 = int'(mem_addr);
                nfl++;
                flush_ack = 1'b1;
                step();
                flush_ack = 1'b0;
                check("walk_flush_drop", flush, 0);
            end else begin
                step();
            end
        end
        check("walk_done", done, 1);
        check("walk_pending", q.size(), 0);
        walk_mode = 1'b0;
        exp_ready = 1'b1;
        exp_flush_done = done;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected $finish");
        $fatal(1);
    end

    initial begin
        bit          sh, sf, sfe;
        int          fa, fe, nfl, a0, a1;
        logic [31:0] fd;

        rsta_n = 1'b0; req = 1'b0; wea = 1'b0; addra = '0; dina = '0; flush_all = 1'b0;
        fetch_ack = 1'b0; flush_ack = 1'b0; mem_din = '0;
        model_reset();
        #1;
        cmp_en = 1'b1;
        check("rst_douta", douta, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_dout", mem_dout, 0);
        check("rst_ready", ready, 1);
        step();
        step();
        rsta_n = 1'b1;

        // Write then read back on an empty cache.
        access(1, 0, 32'd2123000123, 0, 0, 0, sh, sf, fa, fd, sfe, fe);
        check("w0_no_flush", sf, 0);
        check("w0_ready", ready, 1);
        access(0, 0, 0, 0, 0, 0, sh, sf, fa, fd, sfe, fe);
        check("r0_hit", sh, 1);
        check("r0_douta", douta, 32'd2123000123);

        // Read miss with line fill; stray flush_ack during the fetch.
        access(0, 1000, 0, 32'd1002003009, 2, 1, sh, sf, fa, fd, sfe, fe);
        check("r1000_fetch", sfe, 1);
        check("r1000_mem_addr", fe, 1000);
        check("r1000_douta", douta, 32'd1002003009);
        access(0, 1000, 0, 0, 0, 0, sh, sf, fa, fd, sfe, fe);
        check("r1000_rehit", sh, 1);

        // LRU eviction of a dirty line in set 0; stray fetch_ack held 3 cycles in FLUSH.
        access(1, 0, 32'd7, 0, 0, 0, sh, sf, fa, fd, sfe, fe);
        access(1, 512, 32'd998, 0, 0, 0, sh, sf, fa, fd, sfe, fe);
        access(0, 0, 0, 0, 0, 0, sh, sf, fa, fd, sfe, fe);
        access(1, 1024, 32'd5, 0, 3, 1, sh, sf, fa, fd, sfe, fe);
        check("w1024_flush", sf, 1);
        check("w1024_flush_addr", fa, 512);
        check("w1024_flush_data", fd, 998);
        access(0, 0, 0, 0, 0, 0, sh, sf, fa, fd, sfe, fe);
        check("r0_hit_after_evict", sh, 1);
        check("r0_douta_7", douta, 7);
        access(0, 512, 0, 32'd31337, 1, 0, sh, sf, fa, fd, sfe, fe);
        check("r512_fetch", sfe, 1);
        check("r512_fetch_addr", fe, 512);

        // Flush walk over set 0 (both ways dirty), then a clean walk with a competing req.
        do_reset();
        access(1, 0, 32'd11, 0, 0, 0, sh, sf, fa, fd, sfe, fe);
        access(1, 1024, 32'd22, 0, 0, 0, sh, sf, fa, fd, sfe, fe);
        walk(0, nfl, a0, a1);
        check("walk1_count", nfl, 2);
        check("walk1_first", a0, 0);
        check("walk1_second", a1, 1024);
        step();
        walk(1, nfl, a0, a1);
        check("walk2_count", nfl, 0);
        step();
        access(1, 1023, 32'd44, 0, 0, 0, sh, sf, fa, fd, sfe, fe);
        walk(0, nfl, a0, a1);
        check("walk3_count", nfl, 1);
        check("walk3_last_set", a0, 1023);
        step();
        access(0, 0, 0, 0, 0, 0, sh, sf, fa, fd, sfe, fe);
        check("r0_after_walk_hit", sh, 1);
        check("r0_after_walk_data", douta, 11);

        // Reset in the middle of a fetch.
        req = 1'b1; wea = 1'b0; addra = ADDR_W'(1000);
        step();
        req = 1'b0;
        exp_ready = 1'b0; exp_fetch = 1'b1; exp_mem_addr = 1000;
        check("mid_fetch_started", fetch, 1);
        step();
        rsta_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_fetch", fetch, 0);
        check("mid_rst_ready", ready, 1);
        step();
        step();
        rsta_n = 1'b1;
        access(0, 0, 0, 32'd123, 1, 0, sh, sf, fa, fd, sfe, fe);
        check("post_rst_hit", sh, 0);
        check("post_rst_fetch", sfe, 1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/unified_cache_2way.md
UNIFIED_CACHE_2WAY -- requirements
Module: unified_cache_2way

Interface
REQ-001 Parameter WORDS, default 1024, total cache words; power of two, >=4; organised as WORDS/2 sets x 2 ways, one word per line.
REQ-002 Parameter ADDR_W, default 12, word-address width; index = log2(WORDS/2) LSBs, tag = remaining MSBs.
REQ-003 Parameter DATA_W, default 32, data word width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clka  in  1  clock; all state changes on rising edge.
REQ-006 rsta_n  in  1  asynchronous active-low reset.
REQ-007 req  in  1  access request, sampled only while ready=1.
REQ-008 wea  in  1  1=write, 0=read, qualified by req.
REQ-009 addra  in  ADDR_W  access word address.
REQ-010 dina  in  DATA_W  write data.
REQ-011 flush_all  in  1  request write-back of every dirty line, sampled only while ready=1.
REQ-012 douta  out  DATA_W  read data, registered.
REQ-013 ready  out  1  idle, new request accepted.
REQ-014 hit  out  1  one-cycle pulse, the accepted access hit.
REQ-015 flush_done  out  1  one-cycle pulse, flush_all walk complete.
REQ-016 fetch / fetch_ack  out / in  1  memory read request, level held / memory data valid.
REQ-017 flush / flush_ack  out / in  1  memory write request, level held / write accepted.
REQ-018 mem_addr  out  ADDR_W  memory word address for fetch or flush.
REQ-019 mem_dout / mem_din  out / in  DATA_W  write-back data / fetched data.

Function
REQ-020 States SHALL be IDLE, FLUSH, FETCH, WALK; ready=1 only in IDLE.
REQ-021 In IDLE with req=1, the block SHALL compare the tag against both ways of the indexed set within the same cycle.
REQ-022 Read hit: douta = line data and hit=1 on the next edge; LRU updated to point at the other way; state stays IDLE.
REQ-023 Write hit: line written with dina, dirty set, LRU updated, hit=1 next edge; douta unchanged.
REQ-024 Miss victim: the invalid way (way 0 if both invalid), else the LRU way.
REQ-025 Dirty valid victim: next state FLUSH with mem_addr = {victim tag, index} and mem_dout = victim data; otherwise no flush.
REQ-026 In FLUSH: flush=1; mem_addr and mem_dout held stable until flush_ack=1 is sampled; flush drops on the edge after that sample.
REQ-027 Read miss: FETCH with fetch=1 and mem_addr=latched addra until fetch_ack=1 is sampled.
REQ-027a On that edge: line <= mem_din, valid=1, dirty=0, douta <= mem_din, LRU updated; next state IDLE.
REQ-028 Write miss (write-allocate, no fetch): line <= latched dina, valid=1, dirty=1, LRU updated; next state IDLE.
REQ-028a The write-miss allocate SHALL occur in IDLE if no flush is needed, else on the flush_ack edge.
REQ-029 addra, dina, wea and req SHALL be latched on acceptance and ignored while ready=0.
REQ-030 Only the ack matching the current state SHALL be honoured; fetch_ack in FLUSH, flush_ack in FETCH, and any ack in IDLE are ignored.
REQ-031 fetch and flush SHALL never be 1 together.
REQ-032 flush_all in IDLE enters WALK; WALK scans set 0..WORDS/2-1, way 0 then way 1, one line per cycle.
REQ-032a Each dirty line SHALL produce one FLUSH transaction, then be cleared dirty (valid kept); the walk resumes at the next line.
REQ-033 After the last line, flush_done=1 for one cycle and state returns to IDLE; if req and flush_all are both 1, flush_all wins.
REQ-034 hit SHALL be 0 for misses and walks.

Reset
REQ-035 rsta_n=0 SHALL immediately force IDLE and clear all valid, dirty and LRU bits.
REQ-035a Reset SHALL also force douta=0, hit=0, flush_done=0, fetch=0, flush=0, mem_addr=0, mem_dout=0 and ready=1.
REQ-036 Reset during FLUSH, FETCH or WALK SHALL abandon the transaction; dirty data is lost; data array contents are don't-care.

Verification (WORDS=1024, ADDR_W=12, DATA_W=32; addresses 0/512/1024 share set 0)
REQ-037 Write 0<=2123000123 after reset -> no flush, ready stays 1; read 0 -> hit=1, douta=2123000123 one cycle later.
REQ-038 Read 1000 -> fetch=1, mem_addr=1000; fetch_ack with mem_din=1002003009 -> douta=1002003009, ready=1; re-read 1000 -> hit=1.
REQ-039 Write 0<=7, write 512<=998, read 0, write 1024<=5 -> flush=1, mem_addr=512, mem_dout=998 until flush_ack.
REQ-039a Then read 0 -> hit, douta=7; read 512 -> fetch=1.
REQ-040 Dirty lines 0 and 1024 plus flush_all -> two flushes: mem_addr 0 then 1024, with matching data; then flush_done pulse.
REQ-040a A second flush_all -> no flush, flush_done only.
REQ-041 rsta_n=0 mid-FETCH -> fetch=0 at once, ready=1; after release, read 0 -> fetch=1, hit=0.
REQ-042 In FLUSH, drive fetch_ack=1 for 3 cycles -> flush stays 1, state unchanged; flush_ack then completes the transaction.
